// File: rtl/serial_link_axi_mem_resp.sv
// AXI4 memory responder for the far side of the serial link: single outstanding
// transaction, byte-strobed register-file memory, deterministic replay of link traffic.

package serial_link_axi_mem_resp_pkg;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned BusDataWidth = 64;
  localparam int unsigned BusStrbWidth = BusDataWidth / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [BusDataWidth-1:0] data;
    logic [BusStrbWidth-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [BusDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;
endpackage

module serial_link_axi_mem_resp #(
  parameter type         axi_req_t = serial_link_axi_mem_resp_pkg::axi_req_t,
  parameter type         axi_rsp_t = serial_link_axi_mem_resp_pkg::axi_rsp_t,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 256
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);
  import serial_link_axi_mem_resp_pkg::BurstFixed;
  import serial_link_axi_mem_resp_pkg::BurstIncr;
  import serial_link_axi_mem_resp_pkg::RespOkay;
  import serial_link_axi_mem_resp_pkg::RespSlvErr;

  localparam int unsigned IdW   = serial_link_axi_mem_resp_pkg::IdWidth;
  localparam int unsigned AddrW = serial_link_axi_mem_resp_pkg::AddrWidth;
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Write = 2'd1,
    WResp = 2'd2,
    Read  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [IdW-1:0]   id_q, id_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       burst_q, burst_d;
  logic             err_q, err_d;
  logic             werr_q, werr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [IdxW-1:0]      idx;
  logic [AddrW-1:0]     step;
  logic [AddrW-1:0]     next_addr;
  logic [DataWidth-1:0] rdata;
  logic                 mem_we;
  logic                 beat_last;

  serial_link_axi_mem_resp_pkg::ax_chan_t ax_sel;

  // Word index wraps the address modulo the memory size.
  assign idx       = addr_q[IdxW+2:3];
  assign step      = AddrW'(1) << size_q;
  assign next_addr = (burst_q == BurstFixed) ? addr_q : addr_q + step;
  assign rdata     = mem_q[idx];
  assign beat_last = (cnt_q == len_q);
  assign ax_sel    = axi_req_i.aw_valid ? axi_req_i.aw : axi_req_i.ar;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    werr_d    = werr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    axi_rsp_o = '0;

    case (state_q)
      Idle: begin
        // AW has priority; readies are held low while reset is asserted.
        axi_rsp_o.aw_ready = rst_ni;
        axi_rsp_o.ar_ready = rst_ni & ~axi_req_i.aw_valid;
        if (axi_req_i.aw_valid || axi_req_i.ar_valid) begin
          id_d    = ax_sel.id;
          addr_d  = ax_sel.addr;
          len_d   = ax_sel.len;
          size_d  = ax_sel.size;
          burst_d = ax_sel.burst;
          err_d   = ((ax_sel.burst != BurstFixed) && (ax_sel.burst != BurstIncr)) ||
                    (ax_sel.size > 3'd3);
          cnt_d   = 8'd0;
          werr_d  = 1'b0;
          state_d = axi_req_i.aw_valid ? Write : Read;
        end
      end
      Write: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          mem_we = ~err_q;
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (axi_req_i.w.last) begin
            werr_d  = werr_q | err_q | ~beat_last;
            state_d = WResp;
          end else if (beat_last) begin
            werr_d = 1'b1;
          end
        end
      end
      WResp: begin
        axi_rsp_o.b_valid = 1'b1;
        axi_rsp_o.b.id    = id_q;
        axi_rsp_o.b.resp  = werr_q ? RespSlvErr : RespOkay;
        if (axi_req_i.b_ready) state_d = Idle;
      end
      Read: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id    = id_q;
        axi_rsp_o.r.data  = err_q ? '0 : rdata;
        axi_rsp_o.r.resp  = err_q ? RespSlvErr : RespOkay;
        axi_rsp_o.r.last  = beat_last;
        if (axi_req_i.r_ready) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Transaction context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      werr_q  <= werr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-strobed storage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

endmodule
